// File: rtl/bp_cce_uc_req_responder_pkg.sv
// Proc configuration, BedRock message enums and structs used by the uncached
// CCE responder.
package bp_cce_uc_req_responder_pkg;

  typedef enum logic [0:0] {e_bp_default_cfg = 1'b0} bp_params_e;

  localparam int unsigned paddr_width_gp        = 40;
  localparam int unsigned lce_id_width_gp       = 4;
  localparam int unsigned cce_id_width_gp       = 4;
  localparam int unsigned cce_block_width_gp    = 64;
  localparam int unsigned lce_req_data_width_gp = 128;

  function automatic int unsigned cfg_cce_block_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return cce_block_width_gp;
      default:          return cce_block_width_gp;
    endcase
  endfunction

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1, e_bedrock_msg_size_2, e_bedrock_msg_size_4, e_bedrock_msg_size_8,
    e_bedrock_msg_size_16, e_bedrock_msg_size_32, e_bedrock_msg_size_64, e_bedrock_msg_size_128
  } bp_bedrock_msg_size_e;

  typedef enum logic [1:0] {
    e_bedrock_req_rd_miss = 2'd0,
    e_bedrock_req_wr_miss = 2'd1,
    e_bedrock_req_uc_rd   = 2'd2,
    e_bedrock_req_uc_wr   = 2'd3
  } bp_bedrock_req_type_e;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4
  } bp_bedrock_mem_type_e;

  typedef enum logic [3:0] {
    e_bedrock_cmd_sync       = 4'd0,
    e_bedrock_cmd_set_clear  = 4'd1,
    e_bedrock_cmd_transfer   = 4'd2,
    e_bedrock_cmd_set_tag    = 4'd3,
    e_bedrock_cmd_invalidate = 4'd5,
    e_bedrock_cmd_uc_data    = 4'd6,
    e_bedrock_cmd_uc_st_done = 4'd7,
    e_bedrock_cmd_writeback  = 4'd8
  } bp_bedrock_cmd_type_e;

  typedef struct packed {
    bp_bedrock_req_type_e        msg_type;
    bp_bedrock_msg_size_e        size;
    logic [paddr_width_gp-1:0]   addr;
    logic [lce_id_width_gp-1:0]  src_id;
  } bp_bedrock_lce_req_header_s;

  typedef struct packed {
    bp_bedrock_lce_req_header_s       header;
    logic [lce_req_data_width_gp-1:0] data;
  } bp_bedrock_lce_req_msg_s;

  typedef struct packed {
    logic [lce_id_width_gp-1:0] lce_id;
    logic [2:0]                 way_id;
  } bp_bedrock_mem_payload_s;

  typedef struct packed {
    bp_bedrock_mem_type_e      msg_type;
    bp_bedrock_msg_size_e      size;
    logic [paddr_width_gp-1:0] addr;
    bp_bedrock_mem_payload_s   payload;
  } bp_bedrock_mem_header_s;

  typedef struct packed {
    bp_bedrock_mem_header_s        header;
    logic [cce_block_width_gp-1:0] data;
  } bp_bedrock_mem_msg_s;

  typedef struct packed {
    bp_bedrock_cmd_type_e        msg_type;
    bp_bedrock_msg_size_e        size;
    logic [paddr_width_gp-1:0]   addr;
    logic [lce_id_width_gp-1:0]  dst_id;
    logic [cce_id_width_gp-1:0]  src_id;
    logic [2:0]                  way_id;
  } bp_bedrock_lce_cmd_header_s;

  typedef struct packed {
    bp_bedrock_lce_cmd_header_s    header;
    logic [cce_block_width_gp-1:0] data;
  } bp_bedrock_lce_cmd_msg_s;

  localparam int unsigned lce_req_msg_width_gp = $bits(bp_bedrock_lce_req_msg_s);
  localparam int unsigned mem_msg_width_gp     = $bits(bp_bedrock_mem_msg_s);
  localparam int unsigned lce_cmd_msg_width_gp = $bits(bp_bedrock_lce_cmd_msg_s);

endpackage

// File: rtl/bp_cce_uc_req_responder_txn_counter.sv
// Saturating up-counter of completed transactions; holds at all-ones.
module bp_cce_txn_counter
  #(parameter int unsigned width_p = 16)
  (input  logic               clk_i
  ,input  logic               reset_n_i
  ,input  logic               up_i
  ,output logic [width_p-1:0] count_o
  );

  logic [width_p-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (up_i && (count_q != '1))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) count_q <= '0;
    else            count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/bp_cce_uc_req_responder.sv
// Uncached-only CCE responder: turns each LCE uc_rd/uc_wr request into one
// memory command and returns the matching LCE command, one at a time.
module bp_cce_uc_req_responder
  import bp_cce_uc_req_responder_pkg::*;
  #(parameter bp_params_e  bp_params_p   = e_bp_default_cfg
   ,parameter int unsigned count_width_p = 16
   )
  (input  logic                            clk_i
  ,input  logic                            reset_n_i
  ,input  logic [cce_id_width_gp-1:0]      cce_id_i
  ,input  logic [lce_req_msg_width_gp-1:0] lce_req_i
  ,input  logic                            lce_req_v_i
  ,output logic                            lce_req_ready_then_o
  ,output logic [mem_msg_width_gp-1:0]     mem_cmd_o
  ,output logic                            mem_cmd_v_o
  ,input  logic                            mem_cmd_ready_then_i
  ,input  logic [mem_msg_width_gp-1:0]     mem_resp_i
  ,input  logic                            mem_resp_v_i
  ,output logic                            mem_resp_yumi_o
  ,output logic [lce_cmd_msg_width_gp-1:0] lce_cmd_o
  ,output logic                            lce_cmd_v_o
  ,input  logic                            lce_cmd_ready_then_i
  ,output logic                            illegal_req_o
  ,output logic [count_width_p-1:0]        txn_count_o
  );

  localparam int unsigned cce_block_width_lp = cfg_cce_block_width(bp_params_p);

  localparam logic [2:0] e_reset         = 3'd0;
  localparam logic [2:0] e_ready         = 3'd1;
  localparam logic [2:0] e_send_mem_cmd  = 3'd2;
  localparam logic [2:0] e_wait_mem_resp = 3'd3;
  localparam logic [2:0] e_send_lce_cmd  = 3'd4;

  logic [2:0]                    state_d, state_q;
  logic                          reset_done_d, reset_done_q;
  logic                          illegal_d, illegal_q;
  bp_bedrock_lce_req_msg_s       req_d, req_q, lce_req_li;
  logic [cce_block_width_lp-1:0] resp_data_d, resp_data_q;
  bp_bedrock_mem_msg_s           mem_cmd_lo, mem_resp_li;
  bp_bedrock_lce_cmd_msg_s       lce_cmd_lo;
  logic                          is_wr, txn_done;
  logic                          unused_bits;

  assign lce_req_li  = lce_req_i;
  assign mem_resp_li = mem_resp_i;
  assign is_wr       = (req_q.header.msg_type == e_bedrock_req_uc_wr);
  assign unused_bits = ^{mem_resp_li.header, req_q.data[lce_req_data_width_gp-1:cce_block_width_lp]};

  always_comb begin
    state_d              = state_q;
    reset_done_d         = 1'b1;
    illegal_d            = illegal_q;
    req_d                = req_q;
    resp_data_d          = resp_data_q;
    lce_req_ready_then_o = 1'b0;
    mem_cmd_v_o          = 1'b0;
    mem_resp_yumi_o      = 1'b0;
    lce_cmd_v_o          = 1'b0;
    txn_done             = 1'b0;
    case (state_q)
      // Hold one extra cycle after reset release before accepting requests.
      e_reset: if (reset_done_q) state_d = e_ready;
      e_ready: begin
        lce_req_ready_then_o = 1'b1;
        if (lce_req_v_i) begin
          if ((lce_req_li.header.msg_type == e_bedrock_req_uc_rd)
              || (lce_req_li.header.msg_type == e_bedrock_req_uc_wr)) begin
            req_d   = lce_req_li;
            state_d = e_send_mem_cmd;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      e_send_mem_cmd: begin
        mem_cmd_v_o = mem_cmd_ready_then_i;
        if (mem_cmd_ready_then_i) state_d = e_wait_mem_resp;
      end
      e_wait_mem_resp: begin
        mem_resp_yumi_o = mem_resp_v_i;
        if (mem_resp_v_i) begin
          resp_data_d = mem_resp_li.data;
          state_d     = e_send_lce_cmd;
        end
      end
      e_send_lce_cmd: begin
        lce_cmd_v_o = lce_cmd_ready_then_i;
        if (lce_cmd_ready_then_i) begin
          txn_done = 1'b1;
          state_d  = e_ready;
        end
      end
      default: state_d = e_reset;
    endcase
  end

  always_comb begin
    mem_cmd_lo                       = '0;
    mem_cmd_lo.header.msg_type       = is_wr ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;
    mem_cmd_lo.header.size           = req_q.header.size;
    mem_cmd_lo.header.addr           = req_q.header.addr;
    mem_cmd_lo.header.payload.lce_id = req_q.header.src_id;
    mem_cmd_lo.data                  = req_q.data[cce_block_width_lp-1:0];

    lce_cmd_lo                 = '0;
    lce_cmd_lo.header.msg_type = is_wr ? e_bedrock_cmd_uc_st_done : e_bedrock_cmd_uc_data;
    lce_cmd_lo.header.size     = req_q.header.size;
    lce_cmd_lo.header.addr     = req_q.header.addr;
    lce_cmd_lo.header.dst_id   = req_q.header.src_id;
    lce_cmd_lo.header.src_id   = cce_id_i;
    lce_cmd_lo.data            = is_wr ? '0 : resp_data_q;
  end

  // Message buses are held at zero outside the state that owns them.
  assign mem_cmd_o     = (state_q == e_send_mem_cmd) ? mem_cmd_lo : '0;
  assign lce_cmd_o     = (state_q == e_send_lce_cmd) ? lce_cmd_lo : '0;
  assign illegal_req_o = illegal_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= e_reset;
      reset_done_q <= 1'b0;
      illegal_q    <= 1'b0;
      req_q        <= '0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      reset_done_q <= reset_done_d;
      illegal_q    <= illegal_d;
      req_q        <= req_d;
      resp_data_q  <= resp_data_d;
    end
  end

  bp_cce_txn_counter #(.width_p(count_width_p)) txn_counter
    (.clk_i    (clk_i)
    ,.reset_n_i(reset_n_i)
    ,.up_i     (txn_done)
    ,.count_o  (txn_count_o)
    );

  lce_req_protocol_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    lce_req_v_i |-> (state_q == e_ready))
    else $fatal(1, "lce_req_v_i asserted while responder not ready");

endmodule

// File: tb/tb_bp_cce_uc_req_responder.sv
// Directed bench for bp_cce_uc_req_responder, built with a 2-bit counter so
// saturation is reachable in a handful of transactions.
module tb_bp_cce_uc_req_responder;
  import bp_cce_uc_req_responder_pkg::*;

  logic                            clk = 1'b0;
  logic                            reset_n = 1'b0;
  logic [cce_id_width_gp-1:0]      cce_id = 4'hA;
  logic [lce_req_msg_width_gp-1:0] lce_req = '0;
  logic                            lce_req_v = 1'b0;
  logic                            lce_req_ready;
  logic [mem_msg_width_gp-1:0]     mem_cmd;
  logic                            mem_cmd_v;
  logic                            mem_cmd_ready = 1'b0;
  logic [mem_msg_width_gp-1:0]     mem_resp = '0;
  logic                            mem_resp_v = 1'b0;
  logic                            mem_resp_yumi;
  logic [lce_cmd_msg_width_gp-1:0] lce_cmd;
  logic                            lce_cmd_v;
  logic                            lce_cmd_ready = 1'b0;
  logic                            illegal;
  logic [1:0]                      count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_cce_uc_req_responder #(.bp_params_p(e_bp_default_cfg), .count_width_p(2)) dut
    (.clk_i(clk), .reset_n_i(reset_n), .cce_id_i(cce_id)
    ,.lce_req_i(lce_req), .lce_req_v_i(lce_req_v), .lce_req_ready_then_o(lce_req_ready)
    ,.mem_cmd_o(mem_cmd), .mem_cmd_v_o(mem_cmd_v), .mem_cmd_ready_then_i(mem_cmd_ready)
    ,.mem_resp_i(mem_resp), .mem_resp_v_i(mem_resp_v), .mem_resp_yumi_o(mem_resp_yumi)
    ,.lce_cmd_o(lce_cmd), .lce_cmd_v_o(lce_cmd_v), .lce_cmd_ready_then_i(lce_cmd_ready)
    ,.illegal_req_o(illegal), .txn_count_o(count)
    );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input bp_bedrock_req_type_e t, input logic [39:0] a,
                         input bp_bedrock_msg_size_e sz, input logic [3:0] src,
                         input logic [127:0] d);
    bp_bedrock_lce_req_msg_s r;
    r.header.msg_type = t;
    r.header.size     = sz;
    r.header.addr     = a;
    r.header.src_id   = src;
    r.data            = d;
    lce_req           = r;
  endtask

  task automatic set_resp(input logic [63:0] d);
    bp_bedrock_mem_msg_s m;
    m               = '0;
    m.header.msg_type = e_bedrock_mem_wr;
    m.header.addr   = 40'hFF_FFFF_FFFF;
    m.data          = d;
    mem_resp        = m;
  endtask

  // Full transaction with all readies high; ends in e_ready.
  task automatic run_txn(input logic wr, input logic [39:0] a, input logic [63:0] d);
    step();
    set_req(wr ? e_bedrock_req_uc_wr : e_bedrock_req_uc_rd, a, e_bedrock_msg_size_8, 4'h2, {64'h0, d});
    lce_req_v = 1'b1; mem_cmd_ready = 1'b1; lce_cmd_ready = 1'b1;
    step(); lce_req_v = 1'b0;
    step(); set_resp(d); mem_resp_v = 1'b1;
    step(); mem_resp_v = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_cmd_ready = 1'b1; lce_cmd_ready = 1'b1; mem_resp_v = 1'b1;
    repeat (3) step();
    #1 checks++;
    if ({lce_req_ready, mem_cmd_v, lce_cmd_v, mem_resp_yumi, illegal, count, mem_cmd, lce_cmd} !== '0) begin
      errors++; $display("FAIL reset_hold outputs got %h exp 0", {lce_req_ready, mem_cmd_v, lce_cmd_v, mem_resp_yumi, illegal, count});
    end
    reset_n = 1'b1;
    step(); #1 checks++;
    if (lce_req_ready !== 1'b0) begin errors++; $display("FAIL reset_cycle1_ready got %b exp 0", lce_req_ready); end
    checks++;
    if ({mem_cmd_v, lce_cmd_v, mem_resp_yumi, illegal, count, mem_cmd, lce_cmd} !== '0) begin
      errors++; $display("FAIL reset_cycle1_outputs got %b exp 0", {mem_cmd_v, lce_cmd_v, mem_resp_yumi, illegal, count});
    end
    step(); #1 checks++;
    if (lce_req_ready !== 1'b1) begin errors++; $display("FAIL reset_cycle2_ready got %b exp 1", lce_req_ready); end
    checks++;
    if ({mem_cmd_v, lce_cmd_v, mem_resp_yumi, illegal, count} !== '0) begin
      errors++; $display("FAIL reset_cycle2_outputs got %b exp 0", {mem_cmd_v, lce_cmd_v, mem_resp_yumi, illegal, count});
    end
    mem_resp_v = 1'b0;
  endtask

  task automatic test_uc_read();
    bp_bedrock_mem_msg_s     em;
    bp_bedrock_lce_cmd_msg_s el;
    em = '0; em.header.msg_type = e_bedrock_mem_uc_rd; em.header.size = e_bedrock_msg_size_8;
    em.header.addr = 40'h00_8000_0040; em.header.payload.lce_id = 4'h3;
    el = '0; el.header.msg_type = e_bedrock_cmd_uc_data; el.header.size = e_bedrock_msg_size_8;
    el.header.addr = 40'h00_8000_0040; el.header.dst_id = 4'h3; el.header.src_id = 4'hA;
    el.data = 64'hDEAD_BEEF;
    set_req(e_bedrock_req_uc_rd, 40'h00_8000_0040, e_bedrock_msg_size_8, 4'h3, 128'h0);
    lce_req_v = 1'b1; mem_cmd_ready = 1'b1; lce_cmd_ready = 1'b1;
    step(); lce_req_v = 1'b0;
    #1 checks++;
    if (mem_cmd_v !== 1'b1) begin errors++; $display("FAIL rd_mem_cmd_v got %b exp 1", mem_cmd_v); end
    checks++;
    if (mem_cmd !== em) begin errors++; $display("FAIL rd_mem_cmd got %h exp %h", mem_cmd, em); end
    step(); set_resp(64'hDEAD_BEEF); mem_resp_v = 1'b1;
    #1 checks++;
    if ({mem_resp_yumi, mem_cmd_v} !== 2'b10) begin errors++; $display("FAIL rd_yumi got %b exp 10", {mem_resp_yumi, mem_cmd_v}); end
    step(); mem_resp_v = 1'b0;
    #1 checks++;
    if (lce_cmd_v !== 1'b1) begin errors++; $display("FAIL rd_lce_cmd_v got %b exp 1", lce_cmd_v); end
    checks++;
    if (lce_cmd !== el) begin errors++; $display("FAIL rd_lce_cmd got %h exp %h", lce_cmd, el); end
    step(); #1 checks++;
    if ({count, lce_req_ready, lce_cmd_v} !== 4'b0110) begin
      errors++; $display("FAIL rd_count got %b exp 0110", {count, lce_req_ready, lce_cmd_v});
    end
  endtask

  task automatic test_uc_write();
    bp_bedrock_mem_msg_s     em;
    bp_bedrock_lce_cmd_msg_s el;
    em = '0; em.header.msg_type = e_bedrock_mem_uc_wr; em.header.size = e_bedrock_msg_size_4;
    em.header.addr = 40'h100; em.header.payload.lce_id = 4'h5; em.data = 64'h55;
    el = '0; el.header.msg_type = e_bedrock_cmd_uc_st_done; el.header.size = e_bedrock_msg_size_4;
    el.header.addr = 40'h100; el.header.dst_id = 4'h5; el.header.src_id = 4'hA;
    step();
    set_req(e_bedrock_req_uc_wr, 40'h100, e_bedrock_msg_size_4, 4'h5, {64'hFFFF_0000_FFFF_0000, 64'h55});
    lce_req_v = 1'b1;
    step(); lce_req_v = 1'b0;
    #1 checks++;
    if ({mem_cmd_v, mem_cmd} !== {1'b1, em}) begin errors++; $display("FAIL wr_mem_cmd got %b %h exp 1 %h", mem_cmd_v, mem_cmd, em); end
    step(); set_resp(64'h1234_5678); mem_resp_v = 1'b1;
    step(); mem_resp_v = 1'b0;
    #1 checks++;
    if ({lce_cmd_v, lce_cmd} !== {1'b1, el}) begin errors++; $display("FAIL wr_lce_cmd got %b %h exp 1 %h", lce_cmd_v, lce_cmd, el); end
    step(); #1 checks++;
    if (count !== 2'd2) begin errors++; $display("FAIL wr_count got %0d exp 2", count); end
  endtask

  task automatic test_backpressure();
    bp_bedrock_mem_msg_s     em;
    bp_bedrock_lce_cmd_msg_s el;
    em = '0; em.header.msg_type = e_bedrock_mem_uc_rd; em.header.size = e_bedrock_msg_size_16;
    em.header.addr = 40'h2000; em.header.payload.lce_id = 4'h1; em.data = 64'h77;
    el = '0; el.header.msg_type = e_bedrock_cmd_uc_data; el.header.size = e_bedrock_msg_size_16;
    el.header.addr = 40'h2000; el.header.dst_id = 4'h1; el.header.src_id = 4'hA; el.data = 64'hCAFE;
    step();
    set_req(e_bedrock_req_uc_rd, 40'h2000, e_bedrock_msg_size_16, 4'h1, 128'h77);
    lce_req_v = 1'b1; mem_cmd_ready = 1'b0; lce_cmd_ready = 1'b0;
    step(); lce_req_v = 1'b0; set_resp(64'hBAD0); mem_resp_v = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      #1 checks++;
      if ({mem_cmd_v, mem_resp_yumi} !== 2'b00) begin
        errors++; $display("FAIL bp_mem_stall%0d got %b exp 00", i, {mem_cmd_v, mem_resp_yumi});
      end
      step();
    end
    mem_resp_v = 1'b0; mem_cmd_ready = 1'b1;
    #1 checks++;
    if ({mem_cmd_v, mem_cmd} !== {1'b1, em}) begin errors++; $display("FAIL bp_mem_release got %b %h exp 1 %h", mem_cmd_v, mem_cmd, em); end
    step(); mem_cmd_ready = 1'b0; set_resp(64'hCAFE); mem_resp_v = 1'b1;
    step(); mem_resp_v = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      #1 checks++;
      if (lce_cmd_v !== 1'b0) begin errors++; $display("FAIL bp_lce_stall%0d got %b exp 0", i, lce_cmd_v); end
      step();
    end
    lce_cmd_ready = 1'b1;
    #1 checks++;
    if ({lce_cmd_v, lce_cmd} !== {1'b1, el}) begin errors++; $display("FAIL bp_lce_release got %b %h exp 1 %h", lce_cmd_v, lce_cmd, el); end
    step(); mem_cmd_ready = 1'b1;
    #1 checks++;
    if (count !== 2'd3) begin errors++; $display("FAIL bp_count got %0d exp 3", count); end
  endtask

  task automatic test_illegal();
    step();
    set_req(e_bedrock_req_rd_miss, 40'h4000, e_bedrock_msg_size_64, 4'h6, 128'h0);
    lce_req_v = 1'b1;
    #1 checks++;
    if (illegal !== 1'b0) begin errors++; $display("FAIL ill_before got %b exp 0", illegal); end
    step(); lce_req_v = 1'b0;
    #1 checks++;
    if ({illegal, lce_req_ready, mem_cmd_v} !== 3'b110) begin
      errors++; $display("FAIL ill_set got %b exp 110", {illegal, lce_req_ready, mem_cmd_v});
    end
    step(); #1 checks++;
    if ({illegal, lce_req_ready, mem_cmd_v, count} !== 5'b11011) begin
      errors++; $display("FAIL ill_hold got %b exp 11011", {illegal, lce_req_ready, mem_cmd_v, count});
    end
    run_txn(1'b0, 40'h300, 64'h9);
    #1 checks++;
    if ({illegal, count} !== 3'b111) begin errors++; $display("FAIL ill_sticky got %b exp 111", {illegal, count}); end
  endtask

  task automatic test_reset_mid_txn();
    step();
    set_req(e_bedrock_req_uc_rd, 40'h500, e_bedrock_msg_size_8, 4'h4, 128'h0);
    lce_req_v = 1'b1; mem_cmd_ready = 1'b1;
    step(); lce_req_v = 1'b0;
    step();
    reset_n = 1'b0;
    #1 checks++;
    if ({lce_req_ready, mem_cmd_v, lce_cmd_v, illegal, count} !== '0) begin
      errors++; $display("FAIL mid_rst_clear got %b exp 0", {lce_req_ready, mem_cmd_v, lce_cmd_v, illegal, count});
    end
    set_resp(64'h1111); mem_resp_v = 1'b1;
    #1 checks++;
    if (mem_resp_yumi !== 1'b0) begin errors++; $display("FAIL mid_rst_yumi got %b exp 0", mem_resp_yumi); end
    step(); reset_n = 1'b1;
    step(); #1 checks++;
    if ({lce_req_ready, mem_resp_yumi} !== 2'b00) begin errors++; $display("FAIL mid_rst_rel1 got %b exp 00", {lce_req_ready, mem_resp_yumi}); end
    step(); #1 checks++;
    if ({lce_req_ready, mem_resp_yumi, lce_cmd_v} !== 3'b100) begin
      errors++; $display("FAIL mid_rst_rel2 got %b exp 100", {lce_req_ready, mem_resp_yumi, lce_cmd_v});
    end
    mem_resp_v = 1'b0;
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int unsigned i = 0; i < 5; i++) begin
      run_txn(i[0], 40'h1000 + 40'(i * 8), 64'(i));
      #1 checks++;
      if (count !== exp_cnt[i]) begin errors++; $display("FAIL sat_count%0d got %0d exp %0d", i, count, exp_cnt[i]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not complete");
  end

  initial begin
    test_reset();
    test_uc_read();
    test_uc_write();
    test_backpressure();
    test_illegal();
    test_reset_mid_txn();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
